pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer. It generalises the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Instead of a single global `load`, each stage back-pressures independently, supports flush, and can force a reset-value "bubble" word when empty. Callers pack their pc/imm/alu/control/state fields into one `WIDTH`-bit vector.

---
 rtl/pipe_stage_buf.sv | 148 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid buffer.
// Outputs decode from registered state only, so no input reaches an output combinationally.
module pipe_stage_buf #(
  parameter int unsigned          WIDTH          = 32,
  parameter logic [WIDTH-1:0]     RST_VALUE      = '0,
  parameter bit                   CLEAR_ON_EMPTY = 1'b0,
  parameter int unsigned          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_main;
  logic [WIDTH-1:0]   w_main_nxt;
  logic [WIDTH-1:0]   r_skid;
  logic [WIDTH-1:0]   w_skid_nxt;
  logic [CNT_W-1:0]   r_stall;
  logic [CNT_W-1:0]   w_stall_nxt;
  logic               w_accept;
  logic               w_deliver;
  logic               w_stalled;
  logic [WIDTH-1:0]   w_empty_value;

  assign w_accept      = in_valid & in_ready;
  assign w_deliver     = out_valid & out_ready;
  assign w_stalled     = out_valid & ~out_ready;
  // What the main register shows once the stage has nothing left to offer.
  assign w_empty_value = CLEAR_ON_EMPTY ? RST_VALUE : r_main;

  // NOTE: every signal assigned in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    unique case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_main_nxt  = in_data;
        end
      end
      ST_ONE: begin
        if (w_accept && w_deliver) begin
          w_main_nxt = in_data;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_skid_nxt  = in_data;
        end else if (w_deliver) begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = w_empty_value;
        end
      end
      ST_FULL: begin
        if (w_deliver) begin
          w_state_nxt = ST_ONE;
          w_main_nxt  = r_skid;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase

    // A deliver in this cycle still completes downstream; an accepted word is dropped.
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = w_empty_value;
      w_skid_nxt  = r_skid;
    end
  end

  always_comb begin
    w_stall_nxt = r_stall;
    if (stall_clr) begin
      w_stall_nxt = '0;
    end else if (w_stalled && (r_stall != '1)) begin
      w_stall_nxt = r_stall + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= RST_VALUE;
      r_skid  <= RST_VALUE;
      r_stall <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_stall <= w_stall_nxt;
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    unique case (r_state)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign out_data    = r_main;
  assign stall_count = r_stall;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: two instances (clear-on-empty with a 3-bit counter,
// hold-on-empty with a 16-bit counter) share stimulus and are compared to a queue model.
module tb_pipe_stage_buf;

  localparam logic [31:0] RSTV = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        stall_clr;

  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_data;
  logic [1:0]  c_occ;
  logic [2:0]  c_stall;

  logic        h_in_ready, h_out_valid;
  logic [31:0] h_out_data;
  logic [1:0]  h_occ;
  logic [15:0] h_stall;

  pipe_stage_buf #(.WIDTH(32), .RST_VALUE(RSTV), .CLEAR_ON_EMPTY(1'b1), .CNT_W(3)) dut_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .stall_clr(stall_clr), .stall_count(c_stall)
  );

  pipe_stage_buf #(.WIDTH(32), .RST_VALUE(RSTV), .CLEAR_ON_EMPTY(1'b0), .CNT_W(16)) dut_h (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
    .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
    .occupancy(h_occ), .stall_clr(stall_clr), .stall_count(h_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of at most two words plus the last word shown.
  logic [31:0] q[$];
  logic [31:0] last_word;
  int          cnt_c;
  int          cnt_h;
  int          n_assert;
  int          n_fail;
  bit          check_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_c;
    logic [31:0] exp_h;
    int          sz;
    sz = q.size();
    if (sz > 0) begin
      exp_c = q[0];
      exp_h = q[0];
    end else begin
      exp_c = RSTV;
      exp_h = last_word;
    end
    check("c_out_valid", 32'(c_out_valid), 32'(sz != 0));
    check("c_in_ready",  32'(c_in_ready),  32'(sz < 2));
    check("c_occupancy", 32'(c_occ),       32'(sz));
    check("c_out_data",  c_out_data,       exp_c);
    check("c_stall",     32'(c_stall),     32'(cnt_c));
    check("h_out_valid", 32'(h_out_valid), 32'(sz != 0));
    check("h_in_ready",  32'(h_in_ready),  32'(sz < 2));
    check("h_occupancy", 32'(h_occ),       32'(sz));
    check("h_out_data",  h_out_data,       exp_h);
    check("h_stall",     32'(h_stall),     32'(cnt_h));
  endtask

  task automatic model_update();
    bit ov, ir, acc, del;
    if (rst) begin
      q.delete();
      last_word = RSTV;
      cnt_c = 0;
      cnt_h = 0;
    end else begin
      ov  = (q.size() > 0);
      ir  = (q.size() < 2);
      acc = in_valid && ir;
      del = ov && out_ready;
      if (stall_clr) begin
        cnt_c = 0;
        cnt_h = 0;
      end else if (ov && !out_ready) begin
        if (cnt_c < 7)     cnt_c++;
        if (cnt_h < 65535) cnt_h++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (del) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
      if (q.size() > 0) last_word = q[0];
    end
  endtask

  // Apply one cycle of inputs, compare the current state, then advance the model and clock.
  task automatic step(input logic v, input logic [31:0] d, input logic ordy,
                      input logic fl, input logic sc, input logic r);
    rst       = r;
    flush     = fl;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    stall_clr = sc;
    #1;
    if (check_en) check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    check_en  = 1'b0;
    last_word = RSTV;
    cnt_c     = 0;
    cnt_h     = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; stall_clr = 1'b0;

    // Reset for two cycles; state is checked from the second cycle on.
    step(0, 32'h0, 0, 0, 0, 1);
    check_en = 1'b1;
    step(0, 32'h0, 0, 0, 0, 1);
    step(0, 32'h0, 1, 0, 0, 0);

    // Streaming 1..8 with the sink always ready.
    for (int i = 1; i <= 8; i++) step(1, 32'(i), 1, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);

    // Back-pressure: A accepted, sink stalls 3 cycles while B and C are offered.
    step(1, 32'hA, 1, 0, 0, 0);
    step(1, 32'hB, 0, 0, 0, 0);
    step(1, 32'hC, 0, 0, 0, 0);
    step(1, 32'hC, 0, 0, 0, 0);
    step(1, 32'hC, 1, 0, 0, 0);
    step(1, 32'hC, 1, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 1'b0);
    step(0, 32'h0, 1, 0, 1, 0);

    // Flush while FULL with a word offered.
    step(1, 32'h21, 0, 0, 0, 0);
    step(1, 32'h22, 0, 0, 0, 0);
    step(1, 32'h23, 0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);
    // Flush in ONE while an accept is possible, with and without a deliver.
    step(1, 32'h31, 0, 0, 0, 0);
    step(1, 32'h32, 0, 1, 0, 0);
    step(1, 32'h41, 1, 0, 0, 0);
    step(1, 32'h42, 1, 1, 0, 0);
    step(0, 32'h0, 1, 0, 1, 0);

    // Stall-counter saturation (3-bit instance) and clear during a stall.
    step(1, 32'h77, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 1, 0);
    step(0, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);

    // Reset mid-burst while holding 0x55 and 0x66.
    step(1, 32'h55, 0, 0, 0, 0);
    step(1, 32'h66, 0, 0, 0, 0);
    step(1, 32'h99, 1, 0, 0, 1);
    step(0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 63) == 0));
    end
    step(0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
